// File: rtl/pipe_pkg.sv
// Shared definitions for the inter-stage pipeline registers.
package pipe_pkg;

    // Values for the SKID parameter of pipe_stage.
    localparam int PIPE_MODE_PASS = 0;
    localparam int PIPE_MODE_SKID = 1;

    // Width of the occupancy count (0..2 entries).
    localparam int OCC_W = 2;

    // Payload carried across the EX -> MEM boundary.
    typedef struct packed {
        logic [4:0]  rs1_addr;
        logic [4:0]  rs2_addr;
        logic [4:0]  rd_addr;
        logic [31:0] rs1_val;
        logic [31:0] rs2_val;
        logic [31:0] pc;
        logic [31:0] mem_addr;
        logic [31:0] exec_output;
        logic        jump;
        logic [31:0] jump_addr;
        logic [7:0]  instr_id;
        logic        rd_valid;
    } ex_mem_t;

    localparam int EX_MEM_W = $bits(ex_mem_t);

    // Payload carried across the IF -> ID boundary.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [7:0]  instr_id;
    } if_id_t;

    localparam int IF_ID_W = $bits(if_id_t);

endpackage

// File: rtl/pipe_entry.sv
// One valid bit plus payload register with flush, load, clear and hold.
module pipe_entry #(
    parameter int DATA_W     = 32,
    parameter bit CLEAR_DATA = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              load,
    input  logic              clear,
    input  logic [DATA_W-1:0] d,
    output logic              valid,
    output logic [DATA_W-1:0] q
);

    // Flush beats load beats clear; with none asserted the entry holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            q     <= '0;
        end else if (flush) begin
            valid <= 1'b0;
            if (CLEAR_DATA) begin
                q <= '0;
            end
        end else if (load) begin
            valid <= 1'b1;
            q     <= d;
        end else if (clear) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/pipe_stage.sv
// Pipeline-stage register with valid/ready handshake, optional skid entry,
// selective flush and global freeze.
//
// Handshake: a payload moves upstream->stage when in_valid && in_ready at a
// rising edge, and stage->downstream when out_valid && out_ready at a rising
// edge with neither freeze nor flush asserted. in_valid/in_data must not
// depend on in_ready; out_valid/out_data never depend on out_ready.
module pipe_stage
    import pipe_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int SKID       = PIPE_MODE_PASS,
    parameter bit CLEAR_DATA = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              freeze,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [OCC_W-1:0]  occupancy
);

    logic              m_valid;
    logic [DATA_W-1:0] m_data;
    logic              s_valid;
    logic              accept;
    logic              consume;

    assign accept    = in_valid && in_ready;
    assign consume   = m_valid && out_ready && !freeze && !flush;
    assign out_valid = m_valid;
    assign out_data  = m_data;
    assign occupancy = OCC_W'(m_valid) + OCC_W'(s_valid);

    if (SKID == PIPE_MODE_PASS) begin : g_pass
        // Ready looks through to out_ready so a full stage streams at rate.
        assign in_ready = !freeze && !flush && (!m_valid || out_ready);
        assign s_valid  = 1'b0;

        pipe_entry #(.DATA_W(DATA_W), .CLEAR_DATA(CLEAR_DATA)) u_main (
            .clk   (clk),
            .rst_n (rst_n),
            .flush (flush),
            .load  (accept),
            .clear (consume && !accept),
            .d     (in_data),
            .valid (m_valid),
            .q     (m_data)
        );
    end else begin : g_skid
        logic [DATA_W-1:0] s_data;
        logic              m_load;
        logic [DATA_W-1:0] m_d;

        // Ready comes from the skid valid flop only, breaking the timing path.
        assign in_ready = !freeze && !flush && !s_valid;

        // Main entry refills from the skid entry first, else from the input.
        always_comb begin
            m_load = 1'b0;
            m_d    = in_data;
            if (consume && s_valid) begin
                m_load = 1'b1;
                m_d    = s_data;
            end else if (accept && (!m_valid || consume)) begin
                m_load = 1'b1;
            end
        end

        pipe_entry #(.DATA_W(DATA_W), .CLEAR_DATA(CLEAR_DATA)) u_main (
            .clk   (clk),
            .rst_n (rst_n),
            .flush (flush),
            .load  (m_load),
            .clear (consume && !s_valid && !accept),
            .d     (m_d),
            .valid (m_valid),
            .q     (m_data)
        );

        // Skid entry absorbs the one payload accepted while main is stalled.
        pipe_entry #(.DATA_W(DATA_W), .CLEAR_DATA(CLEAR_DATA)) u_skid (
            .clk   (clk),
            .rst_n (rst_n),
            .flush (flush),
            .load  (accept && m_valid && !consume),
            .clear (consume && s_valid),
            .d     (in_data),
            .valid (s_valid),
            .q     (s_data)
        );
    end

endmodule

// File: tb/tb_pipe_stage.sv
// Bench for pipe_stage: a pass-mode instance (CLEAR_DATA=1) and a skid-mode
// instance (CLEAR_DATA=0) share one stimulus stream.
module tb_pipe_stage;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         freeze = 1'b0;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] in_data = '0;

  logic         ir_p, ov_p, ir_s, ov_s;
  logic [W-1:0] od_p, od_s;
  logic [1:0]   occ_p, occ_s;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  pipe_stage #(.DATA_W(W), .SKID(0), .CLEAR_DATA(1'b1)) dut_p (
    .clk(clk), .rst_n(rst_n), .freeze(freeze), .flush(flush),
    .in_valid(in_valid), .in_ready(ir_p), .in_data(in_data),
    .out_valid(ov_p), .out_ready(out_ready), .out_data(od_p),
    .occupancy(occ_p)
  );

  pipe_stage #(.DATA_W(W), .SKID(1), .CLEAR_DATA(1'b0)) dut_s (
    .clk(clk), .rst_n(rst_n), .freeze(freeze), .flush(flush),
    .in_valid(in_valid), .in_ready(ir_s), .in_data(in_data),
    .out_valid(ov_s), .out_ready(out_ready), .out_data(od_s),
    .occupancy(occ_s)
  );

  // ---------------- scoreboard / reference model ----------------
  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q_p[$];
  logic [W-1:0] exp_q_s[$];
  logic [W-1:0] shown_p = '0;
  logic [W-1:0] shown_s = '0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // A stage of capacity cap takes a new payload when not stalled and
  // it has room (pass mode counts the head leaving this cycle as room).
  function automatic logic ref_ready(input int cap, input int size);
    if (freeze || flush) return 1'b0;
    if (cap == 1) return (size == 0) || out_ready;
    return size < 2;
  endfunction

  task automatic model_reset();
    exp_q_p.delete();
    exp_q_s.delete();
    shown_p = '0;
    shown_s = '0;
  endtask

  task automatic check_models();
    chk("p_in_ready", W'(ir_p), W'(ref_ready(1, exp_q_p.size())));
    chk("p_out_valid", W'(ov_p), W'(exp_q_p.size() != 0));
    chk("p_out_data", od_p, (exp_q_p.size() != 0) ? exp_q_p[0] : shown_p);
    chk("p_occupancy", W'(occ_p), W'(exp_q_p.size()));
    chk("s_in_ready", W'(ir_s), W'(ref_ready(2, exp_q_s.size())));
    chk("s_out_valid", W'(ov_s), W'(exp_q_s.size() != 0));
    chk("s_out_data", od_s, (exp_q_s.size() != 0) ? exp_q_s[0] : shown_s);
    chk("s_occupancy", W'(occ_s), W'(exp_q_s.size()));
  endtask

  // Advance both FIFOs by one cycle using the inputs currently applied.
  task automatic model_update();
    logic rp, rs;
    rp = ref_ready(1, exp_q_p.size());
    rs = ref_ready(2, exp_q_s.size());
    if (flush) begin
      exp_q_p.delete();
      shown_p = '0;
      exp_q_s.delete();
    end else if (!freeze) begin
      if (exp_q_p.size() > 0 && out_ready) void'(exp_q_p.pop_front());
      if (in_valid && rp) exp_q_p.push_back(in_data);
      if (exp_q_s.size() > 0 && out_ready) void'(exp_q_s.pop_front());
      if (in_valid && rs) exp_q_s.push_back(in_data);
    end
    if (exp_q_p.size() > 0) shown_p = exp_q_p[0];
    if (exp_q_s.size() > 0) shown_s = exp_q_s[0];
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic fz, input logic fl, input logic iv,
                       input logic [W-1:0] d, input logic orr);
    freeze = fz; flush = fl; in_valid = iv; in_data = d; out_ready = orr;
  endtask

  task automatic sample();
    @(negedge clk);
    check_models();
  endtask

  task automatic advance();
    model_update();
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed table (skid instance expectations) ----------------
  typedef struct {
    logic         fz, fl, iv;
    logic [W-1:0] d;
    logic         orr;
    logic         e_ov;
    logic [W-1:0] e_od;
    logic [1:0]   e_occ;
    logic         e_ir;
  } vec_t;

  vec_t vecs[20];

  initial begin
    // back-pressure: 0xA then 0xB, out_ready low
    vecs[0]  = '{1'b0, 1'b0, 1'b1, 32'hA,  1'b0, 1'b0, 32'h0,  2'd0, 1'b1};
    vecs[1]  = '{1'b0, 1'b0, 1'b1, 32'hB,  1'b0, 1'b1, 32'hA,  2'd1, 1'b1};
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 32'hC,  1'b0, 1'b1, 32'hA,  2'd2, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 32'hA,  2'd2, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 32'hB,  2'd1, 1'b1};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 32'hB,  2'd0, 1'b1};
    // flush during freeze with two entries held
    vecs[6]  = '{1'b0, 1'b0, 1'b1, 32'h11, 1'b0, 1'b0, 32'hB,  2'd0, 1'b1};
    vecs[7]  = '{1'b0, 1'b0, 1'b1, 32'h22, 1'b0, 1'b1, 32'h11, 2'd1, 1'b1};
    vecs[8]  = '{1'b1, 1'b1, 1'b1, 32'h33, 1'b1, 1'b1, 32'h11, 2'd2, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 32'h11, 2'd0, 1'b1};
    // simultaneous accept and consume, main full and skid empty
    vecs[10] = '{1'b0, 1'b0, 1'b1, 32'h44, 1'b0, 1'b0, 32'h11, 2'd0, 1'b1};
    vecs[11] = '{1'b0, 1'b0, 1'b1, 32'h55, 1'b1, 1'b1, 32'h44, 2'd1, 1'b1};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 1'b1, 32'h55, 2'd1, 1'b1};
    // freeze hold for five cycles with out_ready high
    vecs[13] = '{1'b1, 1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 32'h55, 2'd1, 1'b0};
    vecs[14] = '{1'b1, 1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 32'h55, 2'd1, 1'b0};
    vecs[15] = '{1'b1, 1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 32'h55, 2'd1, 1'b0};
    vecs[16] = '{1'b1, 1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 32'h55, 2'd1, 1'b0};
    vecs[17] = '{1'b1, 1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 32'h55, 2'd1, 1'b0};
    vecs[18] = '{1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 32'h55, 2'd1, 1'b1};
    vecs[19] = '{1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 32'h55, 2'd0, 1'b1};

    // reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_p_out_valid", W'(ov_p), '0);
    chk("rst_p_out_data", od_p, '0);
    chk("rst_p_occupancy", W'(occ_p), '0);
    chk("rst_s_out_valid", W'(ov_s), '0);
    chk("rst_s_out_data", od_s, '0);
    chk("rst_s_occupancy", W'(occ_s), '0);
    rst_n = 1'b1;
    model_reset();

    for (int i = 0; i < 20; i++) begin
      drive(vecs[i].fz, vecs[i].fl, vecs[i].iv, vecs[i].d, vecs[i].orr);
      sample();
      chk($sformatf("vec%0d_out_valid", i), W'(ov_s), W'(vecs[i].e_ov));
      chk($sformatf("vec%0d_out_data", i), od_s, vecs[i].e_od);
      chk($sformatf("vec%0d_occupancy", i), W'(occ_s), W'(vecs[i].e_occ));
      chk($sformatf("vec%0d_in_ready", i), W'(ir_s), W'(vecs[i].e_ir));
      advance();
    end

    // streaming 0..7 with out_ready high: ready never drops
    for (int k = 0; k < 8; k++) begin
      drive(1'b0, 1'b0, 1'b1, W'(k), 1'b1);
      sample();
      chk("stream_p_in_ready", W'(ir_p), W'(1));
      chk("stream_s_in_ready", W'(ir_s), W'(1));
      if (k > 0) begin
        chk("stream_p_out_data", od_p, W'(k - 1));
        chk("stream_s_out_data", od_s, W'(k - 1));
      end
      advance();
    end
    drive(1'b0, 1'b0, 1'b0, '0, 1'b1);
    sample(); advance();
    sample(); advance();

    // reset asserted mid-transfer
    drive(1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0);
    sample(); advance();
    sample(); advance();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_p_out_valid", W'(ov_p), '0);
    chk("arst_p_out_data", od_p, '0);
    chk("arst_p_occupancy", W'(occ_p), '0);
    chk("arst_s_out_valid", W'(ov_s), '0);
    chk("arst_s_out_data", od_s, '0);
    chk("arst_s_occupancy", W'(occ_s), '0);
    model_reset();
    drive(1'b0, 1'b0, 1'b0, '0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    drive(1'b0, 1'b0, 1'b1, 32'h77, 1'b0);
    sample(); advance();
    drive(1'b0, 1'b0, 1'b0, '0, 1'b0);
    sample();
    chk("post_rst_p_out_data", od_p, 32'h77);
    chk("post_rst_s_out_data", od_s, 32'h77);
    advance();

    // pass-mode combinational ready
    drive(1'b0, 1'b1, 1'b0, '0, 1'b0);
    sample(); advance();
    drive(1'b0, 1'b0, 1'b1, 32'h66, 1'b0);
    sample(); advance();
    drive(1'b0, 1'b0, 1'b1, 32'h67, 1'b0);
    #1;
    chk("comb_p_in_ready_low", W'(ir_p), W'(0));
    out_ready = 1'b1;
    #1;
    chk("comb_p_in_ready_high", W'(ir_p), W'(1));
    sample(); advance();
    drive(1'b0, 1'b0, 1'b0, '0, 1'b0);
    sample();
    chk("comb_p_occupancy", W'(occ_p), W'(1));
    chk("comb_p_out_data", od_p, 32'h67);
    advance();

    // randomized traffic against the queue model
    for (int n = 0; n < 400; n++) begin
      drive($urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0,
            $urandom_range(0, 9) < 6, $urandom, $urandom_range(0, 1) == 1);
      sample();
      advance();
    end
    drive(1'b0, 1'b0, 1'b0, '0, 1'b1);
    for (int n = 0; n < 3; n++) begin
      sample();
      advance();
    end

    // ---------------- final report ----------------
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
